// File: rtl/prime_pkg.sv
// Shared definitions for the prime-test engine.
//   state_e   : FSM state encoding (IDLE, CHECK)
//   PRIME_MIN : smallest prime; operands below it are never prime
//   WIDTH_DEF : default operand width in bits
package prime_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam int PRIME_MIN = 2;
  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/prime_engine_if.sv
// Request/result bundle of the prime-test engine.
//   en_i    : start request (master -> engine)
//   data_i  : operand n, unsigned (master -> engine)
//   prime_o : 1 = n is prime, meaningful while valid_o = 1
//   valid_o : 1 = idle with a result held, 0 = computing
//   done_o  : one-cycle pulse in the cycle valid_o rises
interface prime_engine_if #(
  parameter int WIDTH = prime_pkg::WIDTH_DEF
);
  logic             en_i;
  logic [WIDTH-1:0] data_i;
  logic             prime_o;
  logic             valid_o;
  logic             done_o;

  modport master (output en_i, data_i, input  prime_o, valid_o, done_o);
  modport slave  (input  en_i, data_i, output prime_o, valid_o, done_o);
endinterface

// File: rtl/prime_engine.sv
// Iterative primality tester using trial division by repeated subtraction.
// A request accepted in IDLE latches n, then each CHECK cycle either
// subtracts the trial divisor d from the remainder r, advances d, or
// finishes. The test stops once d*d exceeds n.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : prime_engine_if slave modport (en_i, data_i, prime_o, valid_o, done_o)
module prime_engine
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  prime_engine_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_CHECK = CHECK;

  logic [0:0]         state;
  logic [WIDTH-1:0]   n;
  logic [WIDTH-1:0]   r;
  // One extra bit so d can step past sqrt(2^WIDTH-1) without wrapping.
  logic [WIDTH:0]     d;
  logic [2*WIDTH-1:0] dd;
  logic               prime_q;
  logic               done_q;

  // d never exceeds about 2^(WIDTH/2)+1, so its square fits in 2*WIDTH bits.
  assign dd = (2*WIDTH)'(d) * (2*WIDTH)'(d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      n       <= '0;
      r       <= '0;
      d       <= (WIDTH+1)'(PRIME_MIN);
      prime_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.en_i) begin
          n       <= bus.data_i;
          r       <= bus.data_i;
          d       <= (WIDTH+1)'(PRIME_MIN);
          prime_q <= 1'b0;
          state   <= S_CHECK;
        end
      end else begin
        if (n < WIDTH'(PRIME_MIN)) begin
          prime_q <= 1'b0;
          done_q  <= 1'b1;
          state   <= S_IDLE;
        end else if (dd > (2*WIDTH)'(n)) begin
          prime_q <= 1'b1;
          done_q  <= 1'b1;
          state   <= S_IDLE;
        end else if ((WIDTH+1)'(r) >= d) begin
          // d <= r here, so its upper bit is clear and truncation is exact.
          r <= r - WIDTH'(d);
        end else if (r == '0) begin
          prime_q <= 1'b0;
          done_q  <= 1'b1;
          state   <= S_IDLE;
        end else begin
          d <= d + 1'b1;
          r <= n;
        end
      end
    end
  end

  assign bus.valid_o = (state == S_IDLE);
  assign bus.prime_o = prime_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_prime_engine.sv
module tb_prime_engine;
  localparam int W = 4;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  prime_engine_if #(.WIDTH(W)) bus ();

  prime_engine #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference of the CHECK-step rules: returns step count and verdict.
  function automatic void ref_model(input int nv, output int lat, output logic pr);
    int rv, dv;
    rv = nv; dv = 2; lat = 0; pr = 1'b0;
    forever begin
      lat++;
      if (nv < 2)               begin pr = 1'b0; return; end
      else if (dv * dv > nv)    begin pr = 1'b1; return; end
      else if (rv >= dv)        rv = rv - dv;
      else if (rv == 0)         begin pr = 1'b0; return; end
      else                      begin dv = dv + 1; rv = nv; end
    end
  endfunction

  // Drives one request and measures it; comparisons happen in the callers.
  // hold=1 keeps en_i high and scrambles data_i during CHECK, and leaves en_i
  // high on return.
  task automatic issue(input logic [W-1:0] nv, input bit hold,
                       output int lat, output logic pr, output logic dn,
                       output logic dn_next, output logic vlow,
                       output bit spur, output bit tout);
    @(negedge clk);
    bus.en_i = 1'b1; bus.data_i = nv;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.en_i = 1'b0;
    vlow = ~bus.valid_o;
    spur = bus.done_o;
    lat = 0; tout = 1'b1; pr = 1'b0; dn = 1'b0; dn_next = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (hold) bus.data_i = W'($urandom);
      if (bus.valid_o) begin
        pr = bus.prime_o; dn = bus.done_o; tout = 1'b0;
        break;
      end
      if (bus.done_o) spur = 1'b1;
    end
    if (!hold && !tout) begin
      @(posedge clk);
      @(negedge clk);
      dn_next = bus.done_o;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en_i = 1'b1; bus.data_i = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.prime_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b prime=%b done=%b, want 1 0 0",
               bus.valid_o, bus.prime_o, bus.done_o);
    end
    bus.en_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] nv [6] = '{4'd3, 4'd9, 4'd4, 4'd0, 4'd1, 4'd2};
    int           el [6] = '{1, 9, 3, 1, 1, 1};
    logic         ep [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat; logic pr, dn, dn2, vl; bit sp, to;
    for (int i = 0; i < 6; i++) begin
      issue(nv[i], 1'b0, lat, pr, dn, dn2, vl, sp, to);
      n_checks++;
      if (to || lat != el[i] || pr !== ep[i]) begin
        n_fail++;
        $display("FAIL directed n=%0d: timeout=%0b lat=%0d prime=%b, want lat=%0d prime=%b",
                 nv[i], to, lat, pr, el[i], ep[i]);
      end
      n_checks++;
      if (vl !== 1'b1 || sp || dn !== 1'b1 || dn2 !== 1'b0) begin
        n_fail++;
        $display("FAIL handshake n=%0d: low_after_E0=%b stray_done=%0b done=%b done_next=%b, want 1 0 1 0",
                 nv[i], vl, sp, dn, dn2);
      end
      // Result must be held while idle.
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.prime_o !== ep[i]) begin
        n_fail++;
        $display("FAIL hold n=%0d: valid=%b prime=%b, want 1 %b", nv[i], bus.valid_o, bus.prime_o, ep[i]);
      end
    end
  endtask

  task automatic test_ignore();
    int lat; logic pr, dn, dn2, vl; bit sp, to;
    issue(4'd9, 1'b1, lat, pr, dn, dn2, vl, sp, to);
    n_checks++;
    if (to || lat != 9 || pr !== 1'b0 || dn !== 1'b1 || sp) begin
      n_fail++;
      $display("FAIL ignore n=9: timeout=%0b lat=%0d prime=%b done=%b stray=%0b, want lat=9 prime=0 done=1",
               to, lat, pr, dn, sp);
    end
    // en_i stayed high through the result edge; only the next edge may take it.
    bus.data_i = 4'd4;
    @(posedge clk);
    @(negedge clk);
    bus.en_i = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back accept: valid=%b done=%b, want 0 0", bus.valid_o, bus.done_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.prime_o !== 1'b0 || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back n=4: valid=%b prime=%b done=%b, want 1 0 1",
               bus.valid_o, bus.prime_o, bus.done_o);
    end
  endtask

  task automatic test_abort();
    bit stray = 1'b0;
    @(negedge clk);
    bus.en_i = 1'b1; bus.data_i = 4'd9;
    @(posedge clk);
    @(negedge clk);
    bus.en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o || bus.valid_o) stray = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stray || bus.valid_o !== 1'b1 || bus.done_o !== 1'b0 || bus.prime_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: early_end=%0b valid=%b done=%b prime=%b, want 0 1 0 0",
               stray, bus.valid_o, bus.done_o, bus.prime_o);
    end
    rst = 1'b0; bus.en_i = 1'b1; bus.data_i = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.en_i = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_after_reset: valid=%b done=%b, want 0 0", bus.valid_o, bus.done_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.prime_o !== 1'b1 || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset n=3: valid=%b prime=%b done=%b, want 1 1 1",
               bus.valid_o, bus.prime_o, bus.done_o);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] primes = 16'h28AC;  // bits 2,3,5,7,11,13
    int lat, elat; logic pr, epr, dn, dn2, vl; bit sp, to;
    for (int i = 0; i < 16; i++) begin
      issue(W'(i), 1'b0, lat, pr, dn, dn2, vl, sp, to);
      ref_model(i, elat, epr);
      n_checks++;
      if (to || pr !== primes[i] || pr !== epr || lat != elat || dn !== 1'b1 || sp) begin
        n_fail++;
        $display("FAIL sweep n=%0d: timeout=%0b prime=%b lat=%0d done=%b stray=%0b, want prime=%b lat=%0d done=1",
                 i, to, pr, lat, dn, sp, primes[i], elat);
      end
    end
  endtask

  initial begin
    bus.en_i = 1'b0;
    bus.data_i = '0;
    rst = 1'b1;
    test_reset();
    test_directed();
    test_ignore();
    test_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prime_engine.md
PRIME_ENGINE -- requirements
Module: prime_engine

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, the operand width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en_i  input  1  start request, sampled on each rising clk edge.
REQ-005 data_i  input  WIDTH  operand n, unsigned.
REQ-006 prime_o  output  1  result, 1 = n is prime; meaningful only while valid_o = 1.
REQ-007 valid_o  output  1  level; 1 = idle with a result held (or reset state); 0 = computing.
REQ-008 done_o  output  1  one-cycle pulse, asserted in the cycle valid_o rises.

Function
REQ-009 The FSM SHALL have two states:
- IDLE: valid_o = 1.
- CHECK: valid_o = 0.
REQ-010 When en_i = 1 in IDLE at an edge (E0), that edge SHALL do all of the following:
- latch n = data_i;
- set r = n and d = 2;
- clear prime_o;
- enter CHECK.
REQ-011 data_i SHALL be ignored outside the edge E0 of REQ-010, and en_i SHALL be ignored while in CHECK.
REQ-012 Each CHECK edge SHALL apply exactly one of the following, in priority order:
- (a) n < 2: prime_o = 0, go to IDLE;
- (b) d*d > n: prime_o = 1, go to IDLE;
- (c) r >= d: r = r - d;
- (d) r = 0: prime_o = 0, go to IDLE;
- (e) otherwise: d = d + 1, r = n.
REQ-013 The product d*d SHALL be computed at 2*WIDTH bits, and d SHALL be WIDTH+1 bits wide, so neither can overflow or wrap.
REQ-014 Only subtraction and comparison SHALL be used: no divider, no modulo operator.
REQ-015 Every edge that takes the FSM from CHECK to IDLE SHALL set valid_o = 1 and done_o = 1 from that edge onward; done_o SHALL be 0 in all other cycles.
REQ-016 prime_o SHALL hold its value in IDLE until the next accepted en_i.
REQ-017 When en_i is accepted at the same edge as a result is issued, the new request SHALL NOT be taken: it is accepted only from IDLE, so the earliest acceptance is the following edge.
REQ-018 Latency SHALL equal the number of CHECK edges given by REQ-012; worst case is bounded by n = 2^WIDTH - 1.

Reset
REQ-019 While rst = 1 at an edge, the block SHALL take these values, overriding any request or computation:
- state = IDLE;
- valid_o = 1, prime_o = 0, done_o = 0;
- n = 0, r = 0, d = 2.
REQ-020 Reset mid-CHECK SHALL abort the computation with no done_o pulse.
REQ-021 en_i SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-022 A shared package prime_pkg SHALL hold:
- the state enum (IDLE, CHECK);
- the constant PRIME_MIN = 2;
- the default WIDTH.
REQ-023 prime_engine SHALL be a single module with no sub-module; its consumer instantiates it with en_i driven by a debounced button pulse.

Verification
REQ-024 Reset: rst high for 2 cycles -> valid_o = 1, prime_o = 0, done_o = 0.
REQ-025 n = 3, en_i pulse at E0 -> valid_o = 0 after E0; at E1 prime_o = 1, valid_o = 1, done_o = 1 for one cycle.
REQ-026 n = 9 -> result at E9: prime_o = 0, with valid_o low across E1..E8; n = 4 -> result at E3, prime_o = 0.
REQ-027 n = 0 and n = 1 -> result at E1, prime_o = 0; n = 2 -> result at E1, prime_o = 1.
REQ-028 Abort and ignore:
- en_i held high and data_i changed during CHECK for n = 9 -> result is unchanged;
- rst at E4 -> valid_o = 1 at E4 and no done_o.
REQ-029 Exhaustive sweep, WIDTH = 4, n = 0..15 -> prime_o = 1 exactly for n in {2, 3, 5, 7, 11, 13}; each latency matches a reference model of REQ-012.
